intersection_phase_arbiter: RTL

INTERSECTION_PHASE_ARBITER -- requirements
Module: intersection_phase_arbiter

---
 rtl/intersection_phase_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/intersection_phase_arbiter.sv
// Four-phase traffic signal arbiter with pedestrian walk service.
// Round-robin over vehicle demand, pedestrian priority, timed yellow/all-red clearance.
module intersection_phase_arbiter #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2,
  parameter int PED_T     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ped_req,
  output logic [3:0] phase_green,
  output logic [3:0] phase_yellow,
  output logic       walk,
  output logic [1:0] active_phase
);

  typedef enum logic [2:0] {
    S_ALL_RED  = 3'd0,
    S_IDLE     = 3'd1,
    S_GREEN    = 3'd2,
    S_YELLOW   = 3'd3,
    S_PED_WALK = 3'd4
  } state_t;

  // Timer holds (elapsed cycles - 1) in the current state.
  localparam logic [7:0] ALL_RED_LAST = 8'(ALL_RED_T - 1);
  localparam logic [7:0] YELLOW_LAST  = 8'(YELLOW_T - 1);
  localparam logic [7:0] PED_LAST     = 8'(PED_T - 1);
  localparam logic [7:0] MIN_LAST     = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MAX_LAST     = 8'(MAX_GREEN - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] timer;
  logic [7:0] next_timer;
  logic [1:0] next_phase;
  logic       ped_pending;
  logic       next_ped;
  logic       arbitrate;
  logic       rr_found;
  logic [1:0] rr_winner;
  logic       green_exit;

  function automatic logic [3:0] onehot(input logic [1:0] p);
    onehot = 4'b0001 << p;
  endfunction

  // Round-robin search from active_phase+1; the current phase is tried last.
  always_comb begin
    logic [1:0] cand;
    rr_found  = 1'b0;
    rr_winner = active_phase;
    cand      = active_phase;
    for (int k = 4; k >= 1; k--) begin
      cand = active_phase + 2'(k);
      if (req[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end else begin
        rr_found  = rr_found;
      end
    end
  end

  assign green_exit = (timer >= MIN_LAST)
                    && ((|(req & ~onehot(active_phase))) || ped_pending)
                    && (!req[active_phase] || (timer >= MAX_LAST));

  // Next-state, timer, phase and pedestrian-latch logic.
  always_comb begin
    next_state = state;
    next_timer = timer;
    next_phase = active_phase;
    next_ped   = ped_pending;
    arbitrate  = 1'b0;
    case (state)
      S_ALL_RED: begin
        if (timer == ALL_RED_LAST) begin
          arbitrate = 1'b1;
        end else begin
          next_timer = timer + 8'd1;
        end
      end
      S_IDLE: begin
        arbitrate = 1'b1;
      end
      S_GREEN: begin
        if (green_exit) begin
          next_state = S_YELLOW;
          next_timer = 8'd0;
        end else if (timer != 8'd255) begin
          next_timer = timer + 8'd1;
        end else begin
          next_timer = timer;
        end
      end
      S_YELLOW: begin
        if (timer == YELLOW_LAST) begin
          next_state = S_ALL_RED;
          next_timer = 8'd0;
        end else begin
          next_timer = timer + 8'd1;
        end
      end
      S_PED_WALK: begin
        if (timer == PED_LAST) begin
          next_state = S_ALL_RED;
          next_timer = 8'd0;
        end else begin
          next_timer = timer + 8'd1;
        end
      end
      default: begin
        next_state = S_ALL_RED;
        next_timer = 8'd0;
      end
    endcase

    if (arbitrate) begin
      next_timer = 8'd0;
      if (ped_pending) begin
        next_state = S_PED_WALK;
        next_ped   = 1'b0;
      end else if (rr_found) begin
        next_state = S_GREEN;
        next_phase = rr_winner;
      end else begin
        next_state = S_IDLE;
      end
    end else begin
      next_timer = next_timer;
    end

    // A press during walk, or in the cycle entering walk, is dropped.
    if (ped_req && (state != S_PED_WALK) && (next_state != S_PED_WALK)) begin
      next_ped = 1'b1;
    end else begin
      next_ped = next_ped;
    end
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_ALL_RED;
      timer        <= 8'd0;
      active_phase <= 2'd3;
      ped_pending  <= 1'b0;
      phase_green  <= 4'b0000;
      phase_yellow <= 4'b0000;
      walk         <= 1'b0;
    end else begin
      state        <= next_state;
      timer        <= next_timer;
      active_phase <= next_phase;
      ped_pending  <= next_ped;
      phase_green  <= (next_state == S_GREEN)  ? onehot(next_phase) : 4'b0000;
      phase_yellow <= (next_state == S_YELLOW) ? onehot(next_phase) : 4'b0000;
      walk         <= (next_state == S_PED_WALK);
    end
  end

endmodule
